// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencer for the five-stage back end.
// Turns stage stall requests, multi-cycle EX ops and MEM-stage redirects into
// per-register hold/flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
module pipeline_ctrl #(
    parameter int unsigned CNT_W = 6,
    parameter int unsigned PC_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_stall_req,
    input  logic             ex_stall_req,
    input  logic             ex_multi_start,
    input  logic [CNT_W-1:0] ex_multi_cycles,
    input  logic             mem_stall_req,
    input  logic             excp_req,
    input  logic [PC_W-1:0]  excp_target,
    output logic [4:0]       stall,
    output logic [4:0]       flush,
    output logic             redirect_en,
    output logic [PC_W-1:0]  redirect_pc,
    output logic             multi_busy,
    output logic             multi_done
);

    typedef enum logic [1:0] {StRun, StMulti, StExcp} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PC_W-1:0]  redirect_pc_q, redirect_pc_d;

    logic start_any;
    logic start_one;
    logic start_long;
    logic cnt_last;

    assign start_any  = (state_q == StRun) && ex_multi_start && (ex_multi_cycles != '0);
    assign start_one  = start_any && (ex_multi_cycles == CNT_W'(1));
    assign start_long = start_any && (ex_multi_cycles >= CNT_W'(2));
    assign cnt_last   = (state_q == StMulti) && (cnt_q == CNT_W'(1));

    // State, down-counter and redirect target registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StRun;
            cnt_q         <= '0;
            redirect_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    // Next-state: exception preempts everything except the redirect cycle itself.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        redirect_pc_d = redirect_pc_q;
        if (state_q == StExcp) begin
            state_d = StRun;
        end else if (excp_req) begin
            state_d       = StExcp;
            cnt_d         = '0;
            redirect_pc_d = excp_target;
        end else if (state_q == StRun) begin
            if (start_long) begin
                state_d = StMulti;
                cnt_d   = ex_multi_cycles - CNT_W'(1);
            end
        end else begin
            // MULTI counts down regardless of memory stalls.
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_last) begin
                state_d = StRun;
            end
        end
    end

    // Outputs: highest-priority stall source picks the hold mask and bubble flush.
    always_comb begin
        stall      = 5'b00000;
        flush      = 5'b00000;
        multi_done = 1'b0;
        if (state_q == StExcp) begin
            flush = 5'b00010;
        end else if (excp_req) begin
            flush = 5'b11110;
        end else begin
            multi_done = start_one || cnt_last;
            if (mem_stall_req) begin
                stall = 5'b01111;
                flush = 5'b10000;
            end else if (ex_stall_req || start_any || (state_q == StMulti)) begin
                stall = 5'b00111;
                flush = 5'b01000;
            end else if (id_stall_req) begin
                stall = 5'b00011;
                flush = 5'b00100;
            end
        end
    end

    assign redirect_en = (state_q == StExcp);
    assign redirect_pc = redirect_pc_q;
    assign multi_busy  = (state_q == StMulti);

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed testbench for pipeline_ctrl with hand-computed expected outputs.
module tb_pipeline_ctrl;

    logic        clk;
    logic        rst;
    logic        id_stall_req;
    logic        ex_stall_req;
    logic        ex_multi_start;
    logic [5:0]  ex_multi_cycles;
    logic        mem_stall_req;
    logic        excp_req;
    logic [31:0] excp_target;
    logic [4:0]  stall;
    logic [4:0]  flush;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        multi_busy;
    logic        multi_done;

    // {stall, flush, redirect_en, multi_busy, multi_done}
    logic [12:0] obs;
    assign obs = {stall, flush, redirect_en, multi_busy, multi_done};

    int checks = 0;
    int errors = 0;

    pipeline_ctrl #(.CNT_W(6), .PC_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .id_stall_req   (id_stall_req),
        .ex_stall_req   (ex_stall_req),
        .ex_multi_start (ex_multi_start),
        .ex_multi_cycles(ex_multi_cycles),
        .mem_stall_req  (mem_stall_req),
        .excp_req       (excp_req),
        .excp_target    (excp_target),
        .stall          (stall),
        .flush          (flush),
        .redirect_en    (redirect_en),
        .redirect_pc    (redirect_pc),
        .multi_busy     (multi_busy),
        .multi_done     (multi_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Apply one cycle of inputs just after the falling edge; outputs settle 1 ns later.
    task automatic drive(input logic id, input logic ex, input logic ms, input logic [5:0] n,
                         input logic mem, input logic ex_req, input logic [31:0] tgt);
        @(negedge clk);
        id_stall_req    = id;
        ex_stall_req    = ex;
        ex_multi_start  = ms;
        ex_multi_cycles = n;
        mem_stall_req   = mem;
        excp_req        = ex_req;
        excp_target     = tgt;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        id_stall_req = 0; ex_stall_req = 0; ex_multi_start = 0; ex_multi_cycles = 0;
        mem_stall_req = 0; excp_req = 0; excp_target = 0;
        #2;
        checks++;
        if (obs !== 13'b0) begin
            errors++; $display("FAIL reset_outputs got=%b exp=%b", obs, 13'b0);
        end
        checks++;
        if (redirect_pc !== 32'h0) begin
            errors++; $display("FAIL reset_redirect_pc got=%h exp=%h", redirect_pc, 32'h0);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_idle_id();
        drive(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (obs !== 13'b0) begin errors++; $display("FAIL idle got=%b exp=%b", obs, 13'b0); end
        drive(1, 0, 0, 0, 0, 0, 0);
        checks++;
        if (obs !== {5'b00011, 5'b00100, 3'b000}) begin
            errors++; $display("FAIL id_stall got=%b exp=%b", obs, {5'b00011, 5'b00100, 3'b000});
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (obs !== 13'b0) begin errors++; $display("FAIL id_release got=%b exp=%b", obs, 13'b0); end
        drive(0, 1, 0, 0, 0, 0, 0);
        checks++;
        if (obs !== {5'b00111, 5'b01000, 3'b000}) begin
            errors++; $display("FAIL ex_stall got=%b exp=%b", obs, {5'b00111, 5'b01000, 3'b000});
        end
    endtask

    task automatic test_multi4();
        logic [12:0] exp_v [5];
        exp_v[0] = {5'b00111, 5'b01000, 3'b000};
        exp_v[1] = {5'b00111, 5'b01000, 3'b010};
        exp_v[2] = {5'b00111, 5'b01000, 3'b010};
        exp_v[3] = {5'b00111, 5'b01000, 3'b011};
        exp_v[4] = 13'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 0) drive(0, 0, 1, 6'd4, 0, 0, 0);
            else        drive(0, 0, (i == 2), 6'd7, 0, 0, 0); // restart in MULTI is ignored
            checks++;
            if (obs !== exp_v[i]) begin
                errors++; $display("FAIL multi4_cycle%0d got=%b exp=%b", i + 1, obs, exp_v[i]);
            end
        end
    endtask

    task automatic test_multi_mem();
        logic [12:0] exp_v [4];
        exp_v[0] = {5'b01111, 5'b10000, 3'b000};
        exp_v[1] = {5'b01111, 5'b10000, 3'b010};
        exp_v[2] = {5'b01111, 5'b10000, 3'b011};
        exp_v[3] = 13'b0;
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, (i == 0), 6'd3, (i < 3), 0, 0);
            checks++;
            if (obs !== exp_v[i]) begin
                errors++; $display("FAIL multi_mem_cycle%0d got=%b exp=%b", i + 1, obs, exp_v[i]);
            end
        end
    endtask

    task automatic test_n_edge();
        drive(0, 0, 1, 6'd1, 0, 0, 0);
        checks++;
        if (obs !== {5'b00111, 5'b01000, 3'b001}) begin
            errors++; $display("FAIL n1 got=%b exp=%b", obs, {5'b00111, 5'b01000, 3'b001});
        end
        drive(0, 0, 1, 6'd0, 0, 0, 0);
        checks++;
        if (obs !== 13'b0) begin errors++; $display("FAIL n0 got=%b exp=%b", obs, 13'b0); end
        drive(0, 0, 0, 6'd0, 0, 0, 0);
        checks++;
        if (obs !== 13'b0) begin errors++; $display("FAIL n0_after got=%b exp=%b", obs, 13'b0); end
    endtask

    task automatic test_excp_multi();
        drive(0, 0, 1, 6'd5, 0, 0, 0);
        drive(0, 0, 0, 6'd0, 0, 1, 32'h1C00_0100);
        checks++;
        if (obs !== {5'b00000, 5'b11110, 3'b010}) begin
            errors++; $display("FAIL excp_cycle got=%b exp=%b", obs, {5'b00000, 5'b11110, 3'b010});
        end
        drive(1, 1, 1, 6'd3, 1, 0, 32'hDEAD_BEEF); // all requests ignored in redirect cycle
        checks++;
        if (obs !== {5'b00000, 5'b00010, 3'b100}) begin
            errors++; $display("FAIL redirect_cycle got=%b exp=%b", obs, {5'b00000, 5'b00010, 3'b100});
        end
        checks++;
        if (redirect_pc !== 32'h1C00_0100) begin
            errors++; $display("FAIL redirect_pc got=%h exp=%h", redirect_pc, 32'h1C00_0100);
        end
        drive(0, 0, 0, 6'd0, 0, 0, 0);
        checks++;
        if (obs !== 13'b0) begin errors++; $display("FAIL after_excp got=%b exp=%b", obs, 13'b0); end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        drive(0, 0, 0, 0, 1, 1, 32'h0000_1000); // exception beats memory stall
        checks++;
        if (obs !== {5'b00000, 5'b11110, 3'b000}) begin
            errors++; $display("FAIL b2b_first got=%b exp=%b", obs, {5'b00000, 5'b11110, 3'b000});
        end
        pulses += int'(redirect_en);
        drive(0, 0, 0, 0, 0, 1, 32'h0000_2000);
        checks++;
        if (obs !== {5'b00000, 5'b00010, 3'b100}) begin
            errors++; $display("FAIL b2b_second got=%b exp=%b", obs, {5'b00000, 5'b00010, 3'b100});
        end
        pulses += int'(redirect_en);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0);
            pulses += int'(redirect_en);
        end
        checks++;
        if (pulses != 1) begin errors++; $display("FAIL b2b_pulses got=%0d exp=%0d", pulses, 1); end
        checks++;
        if (redirect_pc !== 32'h0000_1000) begin
            errors++; $display("FAIL b2b_redirect_pc got=%h exp=%h", redirect_pc, 32'h0000_1000);
        end
    endtask

    task automatic test_async_reset();
        drive(0, 0, 1, 6'd10, 0, 0, 0);
        drive(0, 0, 0, 6'd0, 0, 0, 0);
        drive(0, 0, 0, 6'd0, 0, 0, 0);
        checks++;
        if (obs !== {5'b00111, 5'b01000, 3'b010}) begin
            errors++; $display("FAIL pre_reset got=%b exp=%b", obs, {5'b00111, 5'b01000, 3'b010});
        end
        #1 rst = 1'b0;
        #1;
        checks++;
        if (obs !== 13'b0) begin errors++; $display("FAIL async_reset got=%b exp=%b", obs, 13'b0); end
        checks++;
        if (redirect_pc !== 32'h0) begin
            errors++; $display("FAIL async_reset_pc got=%h exp=%h", redirect_pc, 32'h0);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 6'd0, 0, 0, 0);
            checks++;
            if (obs !== 13'b0) begin
                errors++; $display("FAIL post_reset_idle%0d got=%b exp=%b", i, obs, 13'b0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle_id();
        drive(0, 0, 0, 0, 0, 0, 0);
        test_multi4();
        test_multi_mem();
        test_n_edge();
        test_excp_multi();
        test_back_to_back();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
